host_seq: RTL and testbench
===========================

HOST_SEQ -- requirements
Module: host_seq

Interface
REQ-001 Parameter D, default 12, instruction-space width carried for consistency with the program counter.
REQ-002 Parameter TMO, default 1000, maximum RUN cycles before the job is aborted.
REQ-003 clk  in  1  single clock; all state updates on posedge clk.
REQ-004 reset  in  1  asynchronous, active-low; asserting it forces every register to its reset value immediately.
REQ-005 start  in  1  job request; sampled only in IDLE.
REQ-006 ld_valid  in  1 / ld_ready  out  1  preload beat handshake.
REQ-007 ld_addr  in  8 / ld_data  in  8 / ld_last  in  1  preload address, byte, last-beat marker.
REQ-008 rb_base  in  8 / rb_len  in  8  readback start address and byte count (0 = no readback); sampled on start.
REQ-009 mem_sel  out  1  1 = this block owns the data-memory port, 0 = CPU owns it.
REQ-010 mem_wr_en  out  1 / mem_addr  out  8 / mem_wdata  out  8 / mem_rdata  in  8  data-memory port; read is combinational from mem_addr.
REQ-011 cpu_reset  out  1  active-high hold of the CPU in reset.
REQ-012 cpu_req  out  1 / cpu_done  in  1  run request and CPU completion flag.
REQ-013 rb_valid  out  1 / rb_ready  in  1 / rb_data  out  8 / rb_last  out  1  readback stream.
REQ-014 busy  out  1 / job_done  out  1 / timeout  out  1 / cycles  out  16  status outputs.

Function
REQ-015 The FSM SHALL have exactly the states IDLE, LOAD, HOLD, RUN, READ, FIN.
REQ-016 IDLE->LOAD when start=1; start in any other state SHALL be ignored.
REQ-017 In LOAD: ld_ready=1, mem_sel=1, mem_wr_en=ld_valid, mem_addr=ld_addr, mem_wdata=ld_data.
REQ-018 A preload beat SHALL transfer when ld_valid&ld_ready; a transfer with ld_last=1 moves LOAD->HOLD.
REQ-019 HOLD SHALL last exactly 2 cycles with cpu_reset=1, cpu_req=0, mem_sel=0; then go to RUN.
REQ-020 In RUN: cpu_reset=0, cpu_req=1, mem_sel=0, mem_wr_en=0.
REQ-021 cycles SHALL clear on the first RUN cycle and increment once per RUN cycle, saturating at 16'hFFFF.
REQ-022 cpu_done SHALL be ignored outside RUN.
REQ-023 In RUN, cpu_done=1 moves RUN->READ, or RUN->FIN if rb_len=0.
REQ-024 If the TMO-th RUN cycle completes without cpu_done, the block SHALL set timeout=1 and leave RUN as in REQ-023.
REQ-025 If cpu_done and the timeout condition occur in the same cycle, cpu_done wins and timeout stays 0.
REQ-026 On leaving RUN, cpu_reset SHALL return to 1 and cpu_req to 0.
REQ-027 In READ: mem_sel=1, mem_wr_en=0, mem_addr=rd_ptr, rb_valid=1, rb_data=mem_rdata.
REQ-028 rd_ptr SHALL load rb_base on start and increment by 1 per accepted readback beat, wrapping 8'hFF->8'h00.
REQ-029 rb_last SHALL be 1 on the rb_len-th beat; that beat's transfer moves READ->FIN.
REQ-030 While rb_valid=1 and rb_ready=0, rb_data, rb_last and mem_addr SHALL hold stable.
REQ-031 FIN SHALL last 1 cycle with job_done=1, then return to IDLE.
REQ-032 busy SHALL be 1 in every state except IDLE.
REQ-033 timeout and cycles SHALL be held from FIN until the next start, then cleared.

Reset
REQ-034 While reset=0: state=IDLE, cpu_reset=1, and every other output is 0 (cycles=0, mem_addr=0).
REQ-035 Reset asserted mid-job SHALL abort immediately with no further memory write.
REQ-036 The first start after reset is released SHALL be honoured.

Verification
REQ-037 Preload 3 beats (addr 0,1,2 = 0x11,0x22,0x33, last on the 3rd), cpu_done after 5 RUN cycles, rb_base=0, rb_len=3 -> three writes, cycles=5, readback 0x11,0x22,0x33 with rb_last on beat 3, job_done one cycle.
REQ-038 cpu_done never asserted, TMO=1000 -> timeout=1, cycles=1000, readback still performed.
REQ-039 rb_base=0xFE, rb_len=3 -> readback addresses 0xFE,0xFF,0x00.
REQ-040 rb_ready low 4 cycles mid-readback -> rb_data and mem_addr unchanged, no beat lost or duplicated.
REQ-041 cpu_done high during HOLD, and start pulsed during RUN -> both ignored; RUN lasts until cpu_done rises in RUN.
REQ-042 reset driven low during LOAD after 1 beat -> cpu_reset=1, busy=0, no further writes; a new start then runs a normal job.

Source files
------------

// File: rtl/host_seq.sv
// Host-side job sequencer: preloads CPU data memory, runs the CPU under a
// cycle timeout, then streams a window of data memory back to the host.
//
// state | meaning
// IDLE  | waiting for start
// LOAD  | accepting preload beats into data memory
// HOLD  | two-cycle CPU reset hold before run
// RUN   | CPU released and requested, cycle counter and timeout active
// READ  | streaming rb_len bytes from rd_ptr
// FIN   | one-cycle job_done pulse
module host_seq #(
  parameter int D   = 12,
  parameter int TMO = 1000
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       start,
  input  logic       ld_valid,
  output logic       ld_ready,
  input  logic [7:0] ld_addr,
  input  logic [7:0] ld_data,
  input  logic       ld_last,
  input  logic [7:0] rb_base,
  input  logic [7:0] rb_len,
  output logic       mem_sel,
  output logic       mem_wr_en,
  output logic [7:0] mem_addr,
  output logic [7:0] mem_wdata,
  input  logic [7:0] mem_rdata,
  output logic       cpu_reset,
  output logic       cpu_req,
  input  logic       cpu_done,
  output logic       rb_valid,
  input  logic       rb_ready,
  output logic [7:0] rb_data,
  output logic       rb_last,
  output logic       busy,
  output logic       job_done,
  output logic       timeout,
  output logic [15:0] cycles
);

  localparam logic [2:0] S_IDLE = 3'd0;
  localparam logic [2:0] S_LOAD = 3'd1;
  localparam logic [2:0] S_HOLD = 3'd2;
  localparam logic [2:0] S_RUN  = 3'd3;
  localparam logic [2:0] S_READ = 3'd4;
  localparam logic [2:0] S_FIN  = 3'd5;

  // Run timer is never narrower than the CPU program counter.
  localparam int TW = ($clog2(TMO + 1) > D) ? $clog2(TMO + 1) : D;

  logic [2:0]    state;
  logic          hold_cnt;
  logic [TW-1:0] tmr;
  logic [7:0]    rd_ptr;
  logic [7:0]    rb_cnt;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state    <= S_IDLE;
      hold_cnt <= 1'b0;
      tmr      <= '0;
      rd_ptr   <= 8'h00;
      rb_cnt   <= 8'h00;
      cycles   <= 16'h0000;
      timeout  <= 1'b0;
    end else begin
      case (state)
        S_IDLE: begin
          if (start) begin
            state   <= S_LOAD;
            rd_ptr  <= rb_base;
            rb_cnt  <= rb_len;
            cycles  <= 16'h0000;
            timeout <= 1'b0;
          end
        end
        S_LOAD: begin
          if (ld_valid && ld_last) begin
            state    <= S_HOLD;
            hold_cnt <= 1'b0;
          end
        end
        S_HOLD: begin
          if (hold_cnt) begin
            state  <= S_RUN;
            cycles <= 16'h0000;
            tmr    <= TW'(TMO - 1);
          end else begin
            hold_cnt <= 1'b1;
          end
        end
        S_RUN: begin
          if (cycles != 16'hFFFF) cycles <= cycles + 16'd1;
          // cpu_done takes priority over the terminal count in the same cycle
          if (cpu_done || (tmr == '0)) begin
            state   <= (rb_cnt == 8'h00) ? S_FIN : S_READ;
            timeout <= ~cpu_done;
          end else begin
            tmr <= tmr - TW'(1);
          end
        end
        S_READ: begin
          if (rb_ready) begin
            rd_ptr <= rd_ptr + 8'd1;
            rb_cnt <= rb_cnt - 8'd1;
            if (rb_cnt == 8'd1) state <= S_FIN;
          end
        end
        S_FIN:   state <= S_IDLE;
        default: state <= S_IDLE;
      endcase
    end
  end

  always_comb begin
    ld_ready  = 1'b0;
    mem_sel   = 1'b0;
    mem_wr_en = 1'b0;
    mem_addr  = 8'h00;
    mem_wdata = 8'h00;
    cpu_reset = 1'b1;
    cpu_req   = 1'b0;
    rb_valid  = 1'b0;
    rb_data   = 8'h00;
    rb_last   = 1'b0;
    busy      = (state != S_IDLE);
    job_done  = (state == S_FIN);
    case (state)
      S_LOAD: begin
        ld_ready  = 1'b1;
        mem_sel   = 1'b1;
        mem_wr_en = ld_valid;
        mem_addr  = ld_addr;
        mem_wdata = ld_data;
      end
      S_RUN: begin
        cpu_reset = 1'b0;
        cpu_req   = 1'b1;
      end
      S_READ: begin
        mem_sel  = 1'b1;
        mem_addr = rd_ptr;
        rb_valid = 1'b1;
        rb_data  = mem_rdata;
        rb_last  = (rb_cnt == 8'd1);
      end
      default: ;
    endcase
  end

endmodule

// File: tb/tb_host_seq.sv
// Scoreboard bench for host_seq: stimulus queues expected writes, readback
// beats and job status; a negedge monitor pops and compares them.
module tb_host_seq;

  logic        clk = 1'b0, reset = 1'b0, start = 1'b0;
  logic        ld_valid = 1'b0, ld_last = 1'b0, rb_ready = 1'b1, cpu_done = 1'b0;
  logic [7:0]  ld_addr = 8'h00, ld_data = 8'h00, rb_base = 8'h00, rb_len = 8'h00;
  logic [7:0]  mem_rdata;
  logic        ld_ready, mem_sel, mem_wr_en, cpu_reset, cpu_req;
  logic        rb_valid, rb_last, busy, job_done, timeout;
  logic [7:0]  mem_addr, mem_wdata, rb_data;
  logic [15:0] cycles;

  host_seq #(.D(12), .TMO(1000)) dut (
    .clk(clk), .reset(reset), .start(start),
    .ld_valid(ld_valid), .ld_ready(ld_ready), .ld_addr(ld_addr), .ld_data(ld_data),
    .ld_last(ld_last), .rb_base(rb_base), .rb_len(rb_len),
    .mem_sel(mem_sel), .mem_wr_en(mem_wr_en), .mem_addr(mem_addr),
    .mem_wdata(mem_wdata), .mem_rdata(mem_rdata),
    .cpu_reset(cpu_reset), .cpu_req(cpu_req), .cpu_done(cpu_done),
    .rb_valid(rb_valid), .rb_ready(rb_ready), .rb_data(rb_data), .rb_last(rb_last),
    .busy(busy), .job_done(job_done), .timeout(timeout), .cycles(cycles)
  );

  always #5 clk = ~clk;

  int errors = 0;
  int checks = 0;

  logic [7:0] mem [256];
  assign mem_rdata = mem[mem_addr];
  always @(posedge clk) if (mem_wr_en) mem[mem_addr] = mem_wdata;

  // CPU model: raises cpu_done during its done_n-th RUN cycle (0 = never)
  int   done_n = 0;
  int   run_seen = 0;
  logic hold_glitch = 1'b0;
  always @(posedge clk) run_seen = cpu_req ? run_seen + 1 : 0;
  always @(negedge clk)
    cpu_done = (cpu_req && done_n != 0 && run_seen == done_n - 1) ||
               (hold_glitch && busy && cpu_reset && !mem_sel && !job_done);

  logic [15:0] wq[$];
  logic [16:0] rq[$];
  logic [16:0] sq[$];

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h want %0h", nm, act, exp);
    end
  endtask

  task automatic extra(input string nm, input logic [31:0] act);
    checks++;
    errors++;
    $display("FAIL %s: got %0h want nothing", nm, act);
  endtask

  int   hold_len = 0;
  logic prev_req = 1'b0;
  always @(negedge clk) begin
    if (reset) begin
      if (mem_wr_en) begin
        if (wq.size() == 0) extra("write", {mem_addr, mem_wdata});
        else chk("write", {mem_addr, mem_wdata}, wq.pop_front());
      end
      if (rb_valid) begin
        if (rq.size() == 0) extra("rb_beat", {rb_last, mem_addr, rb_data});
        else if (rb_ready) chk("rb_beat", {rb_last, mem_addr, rb_data}, rq.pop_front());
        else chk("rb_stall", {rb_last, mem_addr, rb_data}, rq[0]);
      end
      if (job_done) begin
        if (sq.size() == 0) extra("status", {timeout, cycles});
        else chk("status", {timeout, cycles}, sq.pop_front());
      end
      if (ld_ready) hold_len = 0;
      else if (busy && cpu_reset && !mem_sel && !job_done) hold_len++;
      if (cpu_req && !prev_req) chk("hold_len", hold_len, 2);
      if (cpu_req) chk("run_outs", {cpu_reset, mem_sel, mem_wr_en}, 3'b000);
      prev_req = cpu_req;
    end
  end

  task automatic do_start(input logic [7:0] b, input logic [7:0] l);
    @(posedge clk); #1;
    rb_base = b; rb_len = l; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
  endtask

  task automatic beat(input logic [7:0] a, input logic [7:0] d, input logic last);
    ld_addr = a; ld_data = d; ld_last = last; ld_valid = 1'b1;
    wq.push_back({a, d});
    @(posedge clk); #1;
    ld_valid = 1'b0; ld_last = 1'b0;
  endtask

  task automatic exp_rb(input logic [7:0] a, input logic [7:0] d, input logic last);
    rq.push_back({last, a, d});
  endtask

  task automatic wait_idle(input int budget, input string nm);
    int n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (busy && n < budget);
    chk({nm, "_idle"}, busy, 0);
    chk({nm, "_wq_left"}, wq.size(), 0);
    chk({nm, "_rq_left"}, rq.size(), 0);
    chk({nm, "_sq_left"}, sq.size(), 0);
    wq.delete(); rq.delete(); sq.delete();
  endtask

  task automatic wait_sig(input int budget, input bit want_rb, input string nm);
    int n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (!(want_rb ? rb_valid : cpu_req) && n < budget);
    chk(nm, want_rb ? rb_valid : cpu_req, 1);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: got timeout want finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    for (int i = 0; i < 256; i++) mem[i] = 8'h00;
    #2;
    chk("rst_flags", {cpu_reset, busy, mem_sel, mem_wr_en, ld_ready, cpu_req,
                      rb_valid, rb_last, job_done, timeout}, 10'b10_0000_0000);
    chk("rst_addr_cycles", {mem_addr, cycles}, 24'h0);
    repeat (2) @(posedge clk);
    #1 reset = 1'b1;

    // basic job: three beats, done on 5th RUN cycle, read back three bytes
    done_n = 5;
    sq.push_back({1'b0, 16'd5});
    exp_rb(8'h00, 8'h11, 1'b0); exp_rb(8'h01, 8'h22, 1'b0); exp_rb(8'h02, 8'h33, 1'b1);
    do_start(8'h00, 8'd3);
    chk("load_ready", {ld_ready, busy, mem_sel}, 3'b111);
    beat(8'h00, 8'h11, 1'b0); beat(8'h01, 8'h22, 1'b0); beat(8'h02, 8'h33, 1'b1);
    wait_idle(200, "jobA");

    // wrapping readback with a 4-cycle stall after the first beat
    done_n = 3;
    sq.push_back({1'b0, 16'd3});
    exp_rb(8'hFE, 8'hA1, 1'b0); exp_rb(8'hFF, 8'hB2, 1'b0); exp_rb(8'h00, 8'hC3, 1'b1);
    do_start(8'hFE, 8'd3);
    beat(8'hFE, 8'hA1, 1'b0); beat(8'hFF, 8'hB2, 1'b0); beat(8'h00, 8'hC3, 1'b1);
    wait_sig(50, 1'b1, "jobB_rb_valid");
    @(posedge clk); #1 rb_ready = 1'b0;
    repeat (4) @(posedge clk);
    #1 rb_ready = 1'b1;
    wait_idle(200, "jobB");

    // timeout: cpu_done never comes, readback still happens
    done_n = 0;
    sq.push_back({1'b1, 16'd1000});
    exp_rb(8'h05, 8'h5A, 1'b1);
    do_start(8'h05, 8'd1);
    beat(8'h05, 8'h5A, 1'b1);
    wait_idle(1200, "jobC");
    repeat (3) @(negedge clk);
    chk("held_status", {timeout, cycles}, {1'b1, 16'd1000});

    // cpu_done during HOLD and start during RUN are ignored; no readback
    hold_glitch = 1'b1;
    done_n = 4;
    sq.push_back({1'b0, 16'd4});
    do_start(8'h00, 8'd0);
    chk("cleared_on_start", {timeout, cycles}, 17'h0);
    beat(8'h10, 8'h77, 1'b1);
    wait_sig(20, 1'b0, "jobD_cpu_req");
    @(posedge clk); #1 start = 1'b1; rb_len = 8'd2; rb_base = 8'h10;
    @(posedge clk); #1 start = 1'b0; rb_len = 8'd0;
    wait_idle(200, "jobD");
    hold_glitch = 1'b0;

    // reset mid-LOAD after one beat
    done_n = 2;
    do_start(8'h00, 8'd0);
    beat(8'h20, 8'h99, 1'b0);
    ld_addr = 8'h21; ld_data = 8'h98; ld_valid = 1'b1; reset = 1'b0;
    #1;
    chk("abort_flags", {cpu_reset, busy, mem_wr_en, ld_ready}, 4'b1000);
    chk("abort_addr_cycles", {mem_addr, cycles}, 24'h0);
    @(posedge clk); #1;
    ld_valid = 1'b0; reset = 1'b1;
    chk("abort_mem", {mem[8'h20], mem[8'h21]}, 16'h9900);
    chk("abort_wq", wq.size(), 0);

    // normal job right after reset release
    sq.push_back({1'b0, 16'd2});
    exp_rb(8'h30, 8'h44, 1'b1);
    do_start(8'h30, 8'd1);
    beat(8'h30, 8'h44, 1'b1);
    wait_idle(200, "jobF");

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
